mux_arb_reg: RTL and testbench

Parametrised N-way, WIDTH-bit registered selector with valid/ready handshaking on every input channel and on the output. It operates in one of two modes: explicit select, or round-robin arbitration among valid channels. It replaces ad-hoc combinational 2:1 muxing wherever multiple producers share one consumer, for example writeback-source or memory-request merging in the sequential processor. It has one output register stage and sustains one transfer per cycle under continuous backpressure-free flow.

---
 rtl/mux_arb_reg.sv | 94 +++++++++
 tb/tb_mux_arb_reg.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// N-way registered selector with valid/ready handshaking on every channel.
// Picks a channel by explicit index or by round-robin, then holds it in one output stage.
module mux_arb_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  output logic [N-1:0]       in_ready_o,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_chan_o,
  input  logic               out_ready_i
);

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SEL_W-1:0] outChan_q, outChan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             accept;
  logic             grantValid;
  logic [SEL_W-1:0] grantIdx;

  assign accept = !outValid_q || out_ready_i;

  // Round-robin scans from ptr upward and wraps; the first valid channel wins.
  always_comb begin
    int idx;
    grantValid = 1'b0;
    grantIdx   = '0;
    idx        = 0;
    if (!mode_i) begin
      for (int i = 0; i < N; i++) begin
        if (int'(sel_i) == i && in_valid_i[i]) begin
          grantValid = 1'b1;
          grantIdx   = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!grantValid && in_valid_i[SEL_W'(idx)]) begin
          grantValid = 1'b1;
          grantIdx   = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    if (!rst_i && accept && grantValid) in_ready_o[grantIdx] = 1'b1;
  end

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outChan_d  = outChan_q;
    ptr_d      = ptr_q;
    if (accept) begin
      outValid_d = grantValid;
      if (grantValid) begin
        outData_d = in_data_i[int'(grantIdx)*WIDTH +: WIDTH];
        outChan_d = grantIdx;
        if (mode_i) ptr_d = SEL_W'((int'(grantIdx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outChan_q  <= '0;
      ptr_q      <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outChan_q  <= outChan_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;
  assign out_chan_o  = outChan_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench for mux_arb_reg (N=4, WIDTH=8): directed scenarios then random traffic
// compared against a transaction-level model of the selector.
module tb_mux_arb_reg;

  localparam int N = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [1:0]       sel;
  logic [N-1:0]     inValid;
  logic [N*WIDTH-1:0] inData;
  logic [N-1:0]     inReady;
  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic [1:0]       outChan;
  logic             outReady;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the output stage and pointer should hold.
  int mValid, mData, mChan, mPtr;

  mux_arb_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sel_i(sel),
    .in_valid_i(inValid), .in_data_i(inData), .in_ready_o(inReady),
    .out_valid_o(outValid), .out_data_o(outData), .out_chan_o(outChan),
    .out_ready_i(outReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Returns the channel the arbitration rules pick, or -1 when nothing is granted.
  function automatic int modelGrant(input int m, input int s, input int v, input int p);
    if (m == 0) return ((s < N) && v[s]) ? s : -1;
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".valid"}, int'(outValid), mValid);
    checkOutput({tag, ".data"}, int'(outData), mData);
    checkOutput({tag, ".chan"}, int'(outChan), mChan);
    checkOutput({tag, ".ptr"}, int'(dut.ptr_q), mPtr);
  endtask

  // Called at posedge+1: drives one cycle, checks in_ready, then checks the registers after the edge.
  task automatic applyStimulus(input string tag, input logic m, input logic [1:0] s,
                               input logic [3:0] v, input logic [31:0] d, input logic r);
    int g, acc, expReady;
    mode = m; sel = s; inValid = v; inData = d; outReady = r;
    #1;
    g = modelGrant(int'(m), int'(s), int'(v), mPtr);
    acc = (mValid == 0 || r) ? 1 : 0;
    expReady = (acc && g >= 0) ? (1 << g) : 0;
    checkOutput({tag, ".ready"}, int'(inReady), expReady);
    @(posedge clk);
    #1;
    if (acc) begin
      if (g >= 0) begin
        mValid = 1;
        mData = int'(d[g*WIDTH +: WIDTH]);
        mChan = g;
        if (m) mPtr = (g + 1) % N;
      end else begin
        mValid = 0;
      end
    end
    checkRegs(tag);
  endtask

  task automatic resetModel();
    mValid = 0; mData = 0; mChan = 0; mPtr = 0;
  endtask

  // Asserts reset between edges and expects immediate clearing.
  task automatic applyAsyncReset(input string tag);
    #1;
    rst = 1'b1;
    resetModel();
    #1;
    checkRegs(tag);
    checkOutput({tag, ".ready"}, int'(inReady), 0);
    @(posedge clk);
    #1;
    checkOutput({tag, ".readyHeld"}, int'(inReady), 0);
    rst = 1'b0;
  endtask

  localparam logic [31:0] DATA_A = 32'h43322110;

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; inValid = 4'hF; inData = DATA_A; outReady = 1'b1;
    resetModel();
    #2;
    checkRegs("initReset");
    checkOutput("initReset.ready", int'(inReady), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus("mode0Sel2", 1'b0, 2'd2, 4'b1111, DATA_A, 1'b1);

    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("fair%0d", i), 1'b1, 2'd0, 4'b1111, DATA_A, 1'b1);

    applyStimulus("setPtr3", 1'b1, 2'd0, 4'b0100, DATA_A, 1'b1);
    applyStimulus("skipTo1", 1'b1, 2'd0, 4'b0010, DATA_A, 1'b1);
    applyStimulus("wrapTo3", 1'b1, 2'd0, 4'b1001, DATA_A, 1'b1);

    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("stall%0d", i), 1'b1, 2'd0, 4'b1111, 32'hA5B6C7D8, 1'b0);
    applyStimulus("release", 1'b1, 2'd0, 4'b1111, 32'hA5B6C7D8, 1'b1);

    applyStimulus("idle0", 1'b1, 2'd0, 4'b0000, 32'h0, 1'b1);
    applyStimulus("idle1", 1'b0, 2'd1, 4'b0000, 32'h0, 1'b1);

    applyStimulus("preReset", 1'b1, 2'd0, 4'b1111, 32'h99887766, 1'b0);
    applyAsyncReset("midReset");

    for (int i = 0; i < 300; i++)
      applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));

    applyStimulus("endFill", 1'b1, 2'd0, 4'b1111, 32'h12345678, 1'b0);
    applyAsyncReset("endReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
